// File: rtl/wave_gen_pkg.sv
// Shared types for the phase-accumulator waveform source.
// Widths here fix the cfg bundle layout used by wave_gen.
package wave_gen_pkg;

    localparam int WG_WIDTH   = 16;
    localparam int WG_PHASE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_e;

    typedef enum logic {
        MODE_SQUARE,
        MODE_TRIANGLE
    } mode_e;

    typedef struct packed {
        logic [WG_PHASE_W-1:0] freq;
        logic [WG_WIDTH-2:0]   amp;
        mode_e                 mode;
    } cfg_t;

endpackage

// File: rtl/wave_gen_shaper.sv
// Phase-to-sample shaper: square always, triangle only with WAVEGEN_TRIANGLE_EN.
module wave_gen_shaper
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = WG_WIDTH
) (
    input  logic                    msb_i,
    input  logic [WIDTH-2:0]        amp_i,
`ifdef WAVEGEN_TRIANGLE_EN
    input  logic [WIDTH-1:0]        ramp_i,
    input  mode_e                   mode_i,
`endif
    output logic signed [WIDTH-1:0] sample_o
);

    logic signed [WIDTH-1:0] pos;

    assign pos = $signed({1'b0, amp_i});

`ifdef WAVEGEN_TRIANGLE_EN
    localparam logic [WIDTH-1:0] BIAS = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] fold;

    // Second half of the phase cycle mirrors the ramp downwards.
    assign fold = msb_i ? ~ramp_i : ramp_i;
`endif

    always_comb begin
        sample_o = msb_i ? -pos : pos;
`ifdef WAVEGEN_TRIANGLE_EN
        if (mode_i == MODE_TRIANGLE) begin
            sample_o = $signed(fold - BIAS);
        end
`endif
    end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform source with valid/ready output and rising-zero sync.
// Triangle mode is built only when WAVEGEN_TRIANGLE_EN is defined.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int WIDTH   = WG_WIDTH,
    parameter int PHASE_W = WG_PHASE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PHASE_W-1:0]      cfg_freq,
    input  logic [WIDTH-2:0]        cfg_amp,
    input  logic                    cfg_mode,
    output logic signed [WIDTH-1:0] dac_data,
    output logic                    dac_valid,
    input  logic                    dac_ready,
    output logic                    sync
);

    if (WIDTH != WG_WIDTH || PHASE_W != WG_PHASE_W || PHASE_W < WIDTH + 1) begin : g_bad_width
        $error("wave_gen: WIDTH/PHASE_W must match wave_gen_pkg");
    end

    state_e                  state_q, state_d;
    cfg_t                    cfg_q, cfg_d;
    cfg_t                    pend_q, pend_d;
    cfg_t                    cfg_new;
    logic                    pend_vld_q, pend_vld_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      phase_add;
    logic                    carry;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic signed [WIDTH-1:0] sample;
    logic                    valid_q, valid_d;
    logic                    sync_q, sync_d;
    logic                    hs;
    logic                    cfg_acc;
    logic                    use_pend;
    logic                    shp_msb;
    logic [WIDTH-2:0]        shp_amp;

    assign hs        = valid_q && dac_ready;
    assign {carry, phase_add} = {1'b0, phase_q} + {1'b0, cfg_q.freq};
    assign cfg_ready = (state_q == IDLE) || !pend_vld_q;
    assign cfg_acc   = cfg_valid && cfg_ready;
    // Pending config switches in only where the accumulator wraps.
    assign use_pend  = hs && carry && pend_vld_q;
    assign shp_msb   = hs ? phase_add[PHASE_W-1] : phase_q[PHASE_W-1];
    assign shp_amp   = use_pend ? pend_q.amp : cfg_q.amp;

`ifdef WAVEGEN_TRIANGLE_EN
    logic [WIDTH-1:0] shp_ramp;
    mode_e            shp_mode;

    assign shp_ramp = hs ? phase_add[PHASE_W-2 -: WIDTH]
                         : phase_q[PHASE_W-2 -: WIDTH];
    assign shp_mode = use_pend ? pend_q.mode : cfg_q.mode;
    assign cfg_new  = '{freq: cfg_freq, amp: cfg_amp, mode: mode_e'(cfg_mode)};
`else
    logic unused_mode;

    assign cfg_new     = '{freq: cfg_freq, amp: cfg_amp, mode: MODE_SQUARE};
    assign unused_mode = cfg_mode ^ logic'(cfg_q.mode) ^ logic'(pend_q.mode);
`endif

    wave_gen_shaper #(
        .WIDTH(WIDTH)
    ) u_shaper (
        .msb_i   (shp_msb),
        .amp_i   (shp_amp),
`ifdef WAVEGEN_TRIANGLE_EN
        .ramp_i  (shp_ramp),
        .mode_i  (shp_mode),
`endif
        .sample_o(sample)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cfg_d      = cfg_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sync_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (cfg_acc) cfg_d = cfg_new;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (cfg_acc) begin
                    pend_d     = cfg_new;
                    pend_vld_d = 1'b1;
                end
                if (!enable) state_d = STOP;
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = sample;
                end else if (hs) begin
                    phase_d = phase_add;
                    data_d  = sample;
                    sync_d  = data_q[WIDTH-1] && !sample[WIDTH-1];
                    if (use_pend) begin
                        cfg_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end
            end
            STOP: begin
                if (!valid_q || hs) begin
                    state_d    = IDLE;
                    phase_d    = '0;
                    valid_d    = 1'b0;
                    data_d     = '0;
                    pend_vld_d = 1'b0;
                    if (cfg_acc) cfg_d = cfg_new;
                    else if (pend_vld_q) cfg_d = pend_q;
                end else if (cfg_acc) begin
                    pend_d     = cfg_new;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cfg_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cfg_q      <= cfg_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
        end
    end

    assign dac_data  = data_q;
    assign dac_valid = valid_q;
    assign sync      = sync_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen against a sample-stream reference model.
module tb_wave_gen;

`ifdef WAVEGEN_TRIANGLE_EN
    localparam bit TRI_EN = 1'b1;
`else
    localparam bit TRI_EN = 1'b0;
`endif
    localparam longint unsigned P32  = 64'h1_0000_0000;
    localparam longint unsigned HALF = 64'h8000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_freq;
    logic [14:0]        cfg_amp;
    logic               cfg_mode;
    logic signed [15:0] dac_data;
    logic               dac_valid;
    logic               dac_ready;
    logic               sync;

    int vecs  = 0;
    int fails = 0;

    longint unsigned    m_ph, m_freq, p_freq;
    int                 m_amp, p_amp;
    bit                 m_tri, p_tri, p_vld, exp_sync;
    logic signed [15:0] m_cur;

    wave_gen dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_freq (cfg_freq),
        .cfg_amp  (cfg_amp),
        .cfg_mode (cfg_mode),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .dac_ready(dac_ready),
        .sync     (sync)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] ref_sample(longint unsigned ph, int amp, bit tri_m);
        longint u;
        if (TRI_EN && tri_m) begin
            u = longint'((ph % HALF) >> 15);
            if (ph >= HALF) u = 65535 - u;
            return 16'(u - 32768);
        end
        return (ph >= HALF) ? 16'(-amp) : 16'(amp);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_pending();
        m_freq = p_freq;
        m_amp  = p_amp;
        m_tri  = p_tri;
        p_vld  = 1'b0;
    endtask

    task automatic advance();
        logic signed [15:0] prev;
        prev = m_cur;
        m_ph = m_ph + m_freq;
        if (m_ph >= P32) begin
            m_ph = m_ph - P32;
            if (p_vld) apply_pending();
        end
        m_cur    = ref_sample(m_ph, m_amp, m_tri);
        exp_sync = (prev < 0) && (m_cur >= 0);
    endtask

    task automatic drive_cfg(input longint unsigned f, input int a, input bit md);
        cfg_freq = f[31:0];
        cfg_amp  = a[14:0];
        cfg_mode = md;
    endtask

    // One RUN cycle: check presented sample, then offer dac_ready=rdy.
    task automatic tick(input bit rdy);
        bit acc;
        chk("run_valid", dac_valid, 1);
        chk("run_data", dac_data, m_cur);
        chk("run_sync", sync, exp_sync);
        chk("run_cfg_ready", cfg_ready, !p_vld);
        dac_ready = rdy;
        acc = cfg_valid && !p_vld;
        if (rdy) advance();
        else exp_sync = 1'b0;
        if (acc) begin
            p_vld  = 1'b1;
            p_freq = cfg_freq;
            p_amp  = cfg_amp;
            p_tri  = cfg_mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cfg(input longint unsigned f, input int a, input bit md);
        chk("idle_cfg_ready", cfg_ready, 1);
        drive_cfg(f, a, md);
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        m_freq = f;
        m_amp  = a;
        m_tri  = md;
    endtask

    task automatic start_run();
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("start_valid_low", dac_valid, 0);
        m_ph     = 0;
        m_cur    = ref_sample(0, m_amp, m_tri);
        exp_sync = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_run();
        enable    = 1'b0;
        dac_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stop_hold_valid", dac_valid, 1);
        chk("stop_hold_data", dac_data, m_cur);
        @(posedge clk);
        #1;
        chk("stop_hold_valid2", dac_valid, 1);
        chk("stop_hold_data2", dac_data, m_cur);
        dac_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_valid", dac_valid, 0);
        chk("idle_data", dac_data, 0);
        chk("idle_sync", sync, 0);
        chk("idle_cfg_ready", cfg_ready, 1);
        if (p_vld) apply_pending();
        dac_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        dac_ready = 1'b0;
        drive_cfg(0, 0, 1'b0);
        m_freq = 0; m_amp = 0; m_tri = 0; p_vld = 0;
        p_freq = 0; p_amp = 0; p_tri = 0;
        m_ph = 0; m_cur = 0; exp_sync = 0;
        #12;
        chk("rst_valid", dac_valid, 0);
        chk("rst_data", dac_data, 0);
        chk("rst_sync", sync, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Square, full-rate.
        idle_cfg(64'h1000_0000, 1000, 1'b0);
        start_run();
        chk("sq_first", dac_data, 16'sd1000);
        for (int i = 0; i < 40; i++) tick(1'b1);
        stop_run();

        // Triangle (square when the shaper is not built).
        idle_cfg(64'h1000_0000, 1000, 1'b1);
        start_run();
        chk("tri_first", dac_data, TRI_EN ? -16'sd32768 : 16'sd1000);
        for (int i = 0; i < 36; i++) tick(1'b1);
        stop_run();

        // Square with random back-pressure.
        idle_cfg(64'h1000_0000, 1000, 1'b0);
        start_run();
        for (int i = 0; i < 80; i++) tick(1'($urandom_range(0, 1)));
        stop_run();

        // Mid-period reconfig; later offers held while pending are ignored.
        start_run();
        for (int i = 0; i < 3; i++) tick(1'b1);
        drive_cfg(64'h2000_0000, 1000, 1'b0);
        cfg_valid = 1'b1;
        tick(1'b1);
        drive_cfg(64'h0800_0000, 5, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        cfg_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick(1'b1);

        // Drain on disable from the negative half, then restart at phase 0.
        for (int i = 0; i < 16 && m_cur >= 0; i++) tick(1'b1);
        chk("neg_half_reached", m_cur < 0, 1);
        stop_run();
        start_run();
        chk("restart_data", dac_data, 16'sd1000);
        chk("restart_sync", sync, 0);
        for (int i = 0; i < 10; i++) tick(1'b1);
        stop_run();

        // Random configs, random back-pressure and random mid-run offers.
        for (int r = 0; r < 3; r++) begin
            idle_cfg(longint'($urandom_range(32'h0200_0000, 32'h2000_0000)),
                     int'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)));
            start_run();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    drive_cfg(longint'($urandom_range(32'h0200_0000, 32'h2000_0000)),
                              int'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)));
                    cfg_valid = 1'b1;
                end else begin
                    cfg_valid = 1'b0;
                end
                tick(1'($urandom_range(0, 1)));
            end
            cfg_valid = 1'b0;
            stop_run();
        end

        // Asynchronous reset mid-run with a config pending.
        idle_cfg(64'h1000_0000, 1234, 1'b0);
        start_run();
        for (int i = 0; i < 3; i++) tick(1'b1);
        drive_cfg(64'h4000_0000, 77, 1'b0);
        cfg_valid = 1'b1;
        tick(1'b1);
        cfg_valid = 1'b0;
        chk("pend_ready_low", cfg_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", dac_valid, 0);
        chk("arst_data", dac_data, 0);
        chk("arst_sync", sync, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_freq = 0; m_amp = 0; m_tri = 0; p_vld = 0;
        start_run();
        chk("post_rst_data", dac_data, 0);
        for (int i = 0; i < 6; i++) tick(1'b1);
        stop_run();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
